// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
// Used by data_mem_responder and data_mem_array.
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = WORD_W / 8;

  localparam logic [WORD_W-1:0] ALIGN_MASK = WORD_W'(BYTE_LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Outcome of an accepted request, held until the response handshake.
  typedef struct packed {
    logic err;
    logic load_ok;
  } resp_t;

  function automatic logic addr_error(
    input logic [WORD_W-1:0] addr,
    input int                idx_w
  );
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr & ALIGN_MASK) != '0;
    out_of_range = (addr >> (idx_w + 2)) != '0;
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised single-port storage; read data registered on access.
// Per-byte write enables exist only with DATA_MEM_BYTE_ENABLE_EN.
module data_mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
`ifdef DATA_MEM_BYTE_ENABLE_EN
  input  logic [BYTE_LANES-1:0]    be_i,
`endif
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  output logic [WORD_W-1:0]        rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Contents are never reset: stores survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
`ifdef DATA_MEM_BYTE_ENABLE_EN
        for (int b = 0; b < BYTE_LANES; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
`else
        mem_q[addr_i] <= wdata_i;
`endif
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: one request at a time, fixed-latency reply.
// Optional byte-enabled stores with DATA_MEM_BYTE_ENABLE_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [WORD_W-1:0]     req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
`ifdef DATA_MEM_BYTE_ENABLE_EN
  input  logic [BYTE_LANES-1:0] req_be,
`endif
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_W-1:0]     resp_rdata,
  output logic                  resp_error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  resp_t            resp_q, resp_d;

  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] arr_rdata;

  assign accept  = req_valid & req_ready;
  assign req_err = addr_error(req_addr, IDX_W);
  assign idx     = req_addr[IDX_W+1:2];

  // The access happens in the acceptance cycle; errors suppress it.
  data_mem_array #(
    .DEPTH   (DEPTH)
  ) u_array (
    .clk_i   (clock),
    .en_i    (accept & ~req_err),
    .we_i    (req_wen),
`ifdef DATA_MEM_BYTE_ENABLE_EN
    .be_i    (req_be),
`endif
    .addr_i  (idx),
    .wdata_i (req_wdata),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          resp_d.err     = req_err;
          resp_d.load_ok = ~req_wen & ~req_err;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
          resp_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // Array read data is only refreshed on acceptance, so it stays stable.
  assign resp_rdata = resp_q.load_ok ? arr_rdata : '0;
  assign resp_error = resp_q.err;

endmodule
